// File: rtl/timer_client_if.sv
// Request/response channel between the core's CSR/MMIO path and timer_client.
// The core drives the master side and timer_client implements the slave side.
interface timer_client_if;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [63:0] reqData;
  logic        respValid;
  logic [63:0] respData;
  logic        respError;

  modport master (
    output reqValid, reqOp, reqData,
    input  reqReady, respValid, respData, respError
  );

  modport slave (
    input  reqValid, reqOp, reqData,
    output reqReady, respValid, respData, respError
  );
endinterface

// File: rtl/timer_client.sv
// Turns single 64-bit mtime/mtimecmp requests into the 32-bit timer access
// sequences that give tear-free reads and glitch-free writes.
module timer_client #(
  parameter int MAX_RETRY = 2
) (
  input  logic          clk,
  input  logic          rst,
  timer_client_if.slave req,
  output logic [3:0]    timerAddr_o,
  output logic [31:0]   timerWriteData_o,
  output logic          timerReadEnable_o,
  output logic          timerWriteEnable_o,
  input  logic [31:0]   timerReadData_i,
  input  logic          timerIrq_i,
  output logic          irqOut_o
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    OP_RD_TIME = 2'd0,
    OP_RD_CMP  = 2'd1,
    OP_WR_TIME = 2'd2,
    OP_WR_CMP  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    T_HI1 = 4'd1,
    T_LO  = 4'd2,
    T_HI2 = 4'd3,
    C_LO  = 4'd4,
    C_HI  = 4'd5,
    W1    = 4'd6,
    W2    = 4'd7,
    W3    = 4'd8,
    RESP  = 4'd9
  } state_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [63:0]   data_q, data_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [63:0]   result_q, result_d;
  logic          err_q, err_d;
  logic          irq_q, irq_d;
  logic          isCmp;

  assign isCmp           = (op_q == OP_WR_CMP);
  assign req.reqReady    = (state_q == IDLE) && !rst;
  assign irqOut_o        = irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_RD_TIME;
      data_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      retry_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      retry_q  <= retry_d;
      result_q <= result_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  // The interrupt is frozen while a multi-word write may leave the timer transiently inconsistent.
  always_comb begin
    irq_d = timerIrq_i;
    if (state_q == W1 || state_q == W2 || state_q == W3) begin
      irq_d = irq_q;
    end
  end

  always_comb begin
    state_d            = state_q;
    op_d               = op_q;
    data_d             = data_q;
    hi_d               = hi_q;
    lo_d               = lo_q;
    retry_d            = retry_q;
    result_d           = result_q;
    err_d              = err_q;
    timerAddr_o        = 4'd0;
    timerWriteData_o   = 32'd0;
    timerReadEnable_o  = 1'b0;
    timerWriteEnable_o = 1'b0;
    req.respValid      = 1'b0;
    req.respData       = 64'd0;
    req.respError      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req.reqValid) begin
          op_d    = op_e'(req.reqOp);
          data_d  = req.reqData;
          retry_d = '0;
          err_d   = 1'b0;
          case (op_e'(req.reqOp))
            OP_RD_TIME: state_d = T_HI1;
            OP_RD_CMP:  state_d = C_LO;
            default:    state_d = W1;
          endcase
        end
      end

      T_HI1: begin
        timerReadEnable_o = 1'b1;
        timerAddr_o       = 4'd4;
        hi_d              = timerReadData_i;
        state_d           = T_LO;
      end

      T_LO: begin
        timerReadEnable_o = 1'b1;
        timerAddr_o       = 4'd0;
        lo_d              = timerReadData_i;
        state_d           = T_HI2;
      end

      // A changed high word means the low word may have wrapped between reads.
      T_HI2: begin
        timerReadEnable_o = 1'b1;
        timerAddr_o       = 4'd4;
        if (timerReadData_i == hi_q) begin
          result_d = {hi_q, lo_q};
          state_d  = RESP;
        end else if (retry_q == RW'(MAX_RETRY)) begin
          result_d = {timerReadData_i, lo_q};
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          hi_d     = timerReadData_i;
          retry_d  = retry_q + RW'(1);
          state_d  = T_LO;
        end
      end

      C_LO: begin
        timerReadEnable_o = 1'b1;
        timerAddr_o       = 4'd8;
        lo_d              = timerReadData_i;
        state_d           = C_HI;
      end

      C_HI: begin
        timerReadEnable_o = 1'b1;
        timerAddr_o       = 4'd12;
        result_d          = {timerReadData_i, lo_q};
        state_d           = RESP;
      end

      // The low word is parked first so no intermediate value can carry or compare early.
      W1: begin
        timerWriteEnable_o = 1'b1;
        timerAddr_o        = isCmp ? 4'd8 : 4'd0;
        timerWriteData_o   = isCmp ? 32'hFFFF_FFFF : 32'd0;
        state_d            = W2;
      end

      W2: begin
        timerWriteEnable_o = 1'b1;
        timerAddr_o        = isCmp ? 4'd12 : 4'd4;
        timerWriteData_o   = data_q[63:32];
        state_d            = W3;
      end

      W3: begin
        timerWriteEnable_o = 1'b1;
        timerAddr_o        = isCmp ? 4'd8 : 4'd0;
        timerWriteData_o   = data_q[31:0];
        result_d           = data_q;
        err_d              = 1'b0;
        state_d            = RESP;
      end

      RESP: begin
        req.respValid = 1'b1;
        req.respData  = result_q;
        req.respError = err_q;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_client.sv
// Directed bench for timer_client against a behavioural mtime/mtimecmp timer stub.
module tb_timer_client;

  localparam logic [1:0] OP_RD_TIME = 2'd0;
  localparam logic [1:0] OP_RD_CMP  = 2'd1;
  localparam logic [1:0] OP_WR_TIME = 2'd2;
  localparam logic [1:0] OP_WR_CMP  = 2'd3;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] data;
    int          expLat;
    logic [63:0] expData;
    logic        expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  timerAddr;
  logic [31:0] timerWriteData;
  logic        timerReadEnable;
  logic        timerWriteEnable;
  logic [31:0] timerReadData;
  logic        timerIrq;
  logic        irqOut;

  logic [63:0] mtime    = 64'd0;
  logic [63:0] mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [31:0] fickleHi = 32'd0;
  logic        fickle   = 1'b0;

  int nChecks   = 0;
  int nPass     = 0;
  int protoViol = 0;

  timer_client_if bus();

  timer_client #(.MAX_RETRY(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .req                (bus),
    .timerAddr_o        (timerAddr),
    .timerWriteData_o   (timerWriteData),
    .timerReadEnable_o  (timerReadEnable),
    .timerWriteEnable_o (timerWriteEnable),
    .timerReadData_i    (timerReadData),
    .timerIrq_i         (timerIrq),
    .irqOut_o           (irqOut)
  );

  always #5 clk = ~clk;

  // Timer stub: a written word takes the write data, otherwise mtime counts up each cycle.
  always @(posedge clk) begin
    if (timerWriteEnable && timerAddr == 4'd0) begin
      mtime <= {mtime[63:32], timerWriteData};
    end else if (timerWriteEnable && timerAddr == 4'd4) begin
      mtime <= {timerWriteData, mtime[31:0]};
    end else begin
      mtime <= mtime + 64'd1;
    end
    if (timerWriteEnable && timerAddr == 4'd8) begin
      mtimecmp <= {mtimecmp[63:32], timerWriteData};
    end
    if (timerWriteEnable && timerAddr == 4'd12) begin
      mtimecmp <= {timerWriteData, mtimecmp[31:0]};
    end
    if (timerReadEnable && timerAddr == 4'd4) begin
      fickleHi <= fickleHi + 32'd1;
    end
  end

  always_comb begin
    timerReadData = 32'd0;
    case (timerAddr)
      4'd0:    timerReadData = fickle ? 32'h1234_5678 : mtime[31:0];
      4'd4:    timerReadData = fickle ? fickleHi : mtime[63:32];
      4'd8:    timerReadData = mtimecmp[31:0];
      4'd12:   timerReadData = mtimecmp[63:32];
      default: timerReadData = 32'd0;
    endcase
  end

  assign timerIrq = (mtime >= mtimecmp);

  always @(negedge clk) begin
    if (!rst) begin
      if (timerReadEnable && timerWriteEnable) protoViol <= protoViol + 1;
      if (bus.reqReady && bus.respValid) protoViol <= protoViol + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one request and returns the accept-to-response latency (-1 on timeout).
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] data,
                               output int lat, output logic [63:0] rdata,
                               output logic rerr);
    int guard;
    guard         = 0;
    rdata         = 64'd0;
    rerr          = 1'b0;
    bus.reqValid  = 1'b1;
    bus.reqOp     = op;
    bus.reqData   = data;
    while (!bus.reqReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.reqReady) begin
      bus.reqValid = 1'b0;
      lat          = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.reqValid = 1'b0;
    lat          = 1;
    while (!bus.respValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.respValid) lat = -1;
    rdata = bus.respData;
    rerr  = bus.respError;
  endtask

  function automatic logic [127:0] outVec();
    return 128'({bus.reqReady, bus.respValid, bus.respError, timerReadEnable,
                 timerWriteEnable, irqOut, timerAddr, timerWriteData, bus.respData});
  endfunction

  initial begin
    vec_t        vecs [6];
    int          lat;
    logic [63:0] rd;
    logic        rerr;
    logic [31:0] base;
    int          guard;
    int          accepts;
    int          resps;

    vecs[0] = '{"wr_time_f0",  OP_WR_TIME, 64'h0000_0001_FFFF_FFF0, 4, 64'h0000_0001_FFFF_FFF0, 1'b0};
    vecs[1] = '{"rd_time_f3",  OP_RD_TIME, 64'd0,                   4, 64'h0000_0001_FFFF_FFF3, 1'b0};
    vecs[2] = '{"wr_time_fd",  OP_WR_TIME, 64'h0000_0001_FFFF_FFFD, 4, 64'h0000_0001_FFFF_FFFD, 1'b0};
    vecs[3] = '{"rd_time_wrap",OP_RD_TIME, 64'd0,                   6, 64'h0000_0002_0000_0002, 1'b0};
    vecs[4] = '{"wr_cmp",      OP_WR_CMP,  64'h1234_5678_9ABC_DEF0, 4, 64'h1234_5678_9ABC_DEF0, 1'b0};
    vecs[5] = '{"rd_cmp",      OP_RD_CMP,  64'd0,                   3, 64'h1234_5678_9ABC_DEF0, 1'b0};

    bus.reqValid = 1'b0;
    bus.reqOp    = 2'd0;
    bus.reqData  = 64'd0;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", outVec(), 128'd0);
    rst = 1'b0;
    #1 checkOutput("ready after reset", 128'(bus.reqReady), 128'd1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, lat, rd, rerr);
      checkOutput({vecs[i].name, " latency"}, 128'(lat), 128'(vecs[i].expLat));
      checkOutput({vecs[i].name, " data"},    128'(rd),  128'(vecs[i].expData));
      checkOutput({vecs[i].name, " error"},   128'(rerr), 128'(vecs[i].expErr));
    end

    @(negedge clk);
    fickle = 1'b1;
    base   = fickleHi;
    applyStimulus(OP_RD_TIME, 64'd0, lat, rd, rerr);
    checkOutput("retry exhaust latency", 128'(lat), 128'd8);
    checkOutput("retry exhaust error", 128'(rerr), 128'd1);
    checkOutput("retry exhaust data", 128'(rd), 128'({base + 32'd3, 32'h1234_5678}));
    checkOutput("retry exhaust hi reads", 128'(fickleHi - base), 128'd4);
    fickle = 1'b0;

    applyStimulus(OP_WR_TIME, 64'h50, lat, rd, rerr);
    checkOutput("wr_time_50 latency", 128'(lat), 128'd4);
    @(negedge clk);
    bus.reqValid = 1'b1;
    bus.reqOp    = OP_WR_CMP;
    bus.reqData  = 64'h100;
    @(negedge clk);
    bus.reqValid = 1'b0;
    checkOutput("wr_cmp W1 strobe", 128'({timerReadEnable, timerWriteEnable, irqOut, timerAddr, timerWriteData}),
                128'({1'b0, 1'b1, 1'b0, 4'd8, 32'hFFFF_FFFF}));
    @(negedge clk);
    checkOutput("wr_cmp W2 strobe", 128'({timerReadEnable, timerWriteEnable, irqOut, timerAddr, timerWriteData}),
                128'({1'b0, 1'b1, 1'b0, 4'd12, 32'h0}));
    @(negedge clk);
    checkOutput("wr_cmp W3 strobe", 128'({timerReadEnable, timerWriteEnable, irqOut, timerAddr, timerWriteData}),
                128'({1'b0, 1'b1, 1'b0, 4'd8, 32'h100}));
    @(negedge clk);
    checkOutput("wr_cmp resp", 128'({bus.respValid, bus.respError, irqOut, bus.respData}),
                128'({1'b1, 1'b0, 1'b0, 64'h100}));

    guard = 0;
    while (!timerIrq && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("raw irq rises", 128'(timerIrq), 128'd1);
    checkOutput("irqOut lags raw irq", 128'(irqOut), 128'd0);
    @(negedge clk);
    checkOutput("irqOut follows", 128'(irqOut), 128'd1);

    applyStimulus(OP_RD_CMP, 64'd0, lat, rd, rerr);
    checkOutput("rd_cmp_100 latency", 128'(lat), 128'd3);
    checkOutput("rd_cmp_100 data", 128'(rd), 128'h100);

    @(negedge clk);
    bus.reqValid = 1'b1;
    bus.reqOp    = OP_WR_CMP;
    bus.reqData  = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    bus.reqValid = 1'b0;
    @(negedge clk);
    checkOutput("abort W2 strobe", 128'({timerWriteEnable, timerAddr, timerWriteData}),
                128'({1'b1, 4'd12, 32'hAAAA_BBBB}));
    #1 rst = 1'b1;
    #1 checkOutput("mid-sequence reset outputs", outVec(), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("ready after mid reset", 128'(bus.reqReady), 128'd1);
    applyStimulus(OP_RD_CMP, 64'd0, lat, rd, rerr);
    checkOutput("rd_cmp after abort latency", 128'(lat), 128'd3);
    checkOutput("rd_cmp after abort data", 128'(rd), 128'h0000_0000_FFFF_FFFF);

    @(negedge clk);
    bus.reqValid = 1'b1;
    bus.reqOp    = OP_RD_CMP;
    accepts      = 0;
    resps        = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.reqValid && bus.reqReady) accepts++;
      if (bus.respValid) resps++;
      @(negedge clk);
    end
    bus.reqValid = 1'b0;
    checkOutput("held valid accepts", 128'(accepts), 128'd10);
    checkOutput("held valid responses", 128'(resps), 128'd10);

    @(negedge clk);
    checkOutput("protocol violations", 128'(protoViol), 128'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/timer_client.md
# timer_client

Bus-side initiator for the memory-mapped machine timer. It turns single 64-bit requests from the core (read/write `mtime`, read/write `mtimecmp`) into the 32-bit register access sequences the timer requires:
- tear-free reads of the free-running `mtime`;
- glitch-free updates of `mtimecmp`.

It sits between the core's CSR/MMIO path and the timer, and forwards a registered, sequence-masked timer interrupt.

## Interface
Parameters:
- MAX_RETRY, 2, number of `mtime` re-reads allowed after a high-word mismatch before the error response.

Ports:
- clk  input  1  clock; one clock domain.
- rst  input  1  reset, asynchronous, active-high.
- reqValid  input  1  request present.
- reqReady  output  1  request accepted when reqValid && reqReady.
- reqOp  input  2  operation: 0 RD_TIME, 1 RD_CMP, 2 WR_TIME, 3 WR_CMP.
- reqData  input  64  write data; ignored for reads.
- respValid  output  1  one-cycle completion pulse.
- respData  output  64  read result, or echo of the written data.
- respError  output  1  valid with respValid; RD_TIME retries exhausted.
- timerAddr  output  4  timer byte address: 0 time lo, 4 time hi, 8 cmp lo, 12 cmp hi.
- timerWriteData  output  32  timer write data.
- timerReadEnable  output  1  timer read strobe.
- timerWriteEnable  output  1  timer write strobe.
- timerReadData  input  32  timer read data; combinational from timerAddr, same cycle.
- timerIrq  input  1  raw timer compare interrupt.
- irqOut  output  1  registered, masked interrupt to the core.

## Operation
- States: IDLE, T_HI1, T_LO, T_HI2, C_LO, C_HI, W1, W2, W3, RESP.
- reqReady = (state == IDLE) && !rst. Acceptance latches reqOp and reqData.
- RD_TIME sequence: T_HI1 → T_LO → T_HI2.
  - T_HI1 reads addr 4 into H1. T_LO reads addr 0 into L. T_HI2 reads addr 4 into H2.
  - If H2 == H1, go to RESP with {H1, L}.
  - Else H1 <= H2, retries++, back to T_LO.
  - If the mismatch occurs with retries == MAX_RETRY, go to RESP with respError = 1 and respData = {H2, L}.
- RD_CMP sequence: C_LO reads addr 8, C_HI reads addr 12, then RESP with {hi, lo}.
- WR_CMP sequence:
  - W1 writes addr 8 = 0xFFFF_FFFF.
  - W2 writes addr 12 = reqData[63:32].
  - W3 writes addr 8 = reqData[31:0].
- WR_TIME sequence:
  - W1 writes addr 0 = 0.
  - W2 writes addr 4 = reqData[63:32].
  - W3 writes addr 0 = reqData[31:0].
  - Zeroing the low word first prevents a carry into the high word. Timer `mtime` equals reqData exactly in the cycle after W3.
- Write responses: RESP echoes reqData, respError = 0.
- Strobes: timerReadEnable = 1 only in read states; timerWriteEnable = 1 only in W1–W3. Never both at once. timerAddr = 0 and timerWriteData = 0 in IDLE/RESP.
- RESP: respValid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- irqOut:
  - irqOut <= timerIrq every cycle except during W1–W3 of WR_CMP or WR_TIME, when it holds its value.
  - It resumes tracking in RESP.
- Retry counter width: clog2(MAX_RETRY+1). It is cleared on accept.

## Timing
- Reset (asserted at any time, including mid-sequence): state IDLE, reqReady 0, respValid 0, respData 0, respError 0, timerReadEnable 0, timerWriteEnable 0, timerAddr 0, timerWriteData 0, irqOut 0. Partially written timer registers are not restored.
- Accept at cycle N. Response cycle:
  - RD_TIME: respValid at N+4, plus 2 cycles per retry.
  - RD_CMP: N+3.
  - WR_TIME and WR_CMP: N+4.
- Next accept possible at response cycle + 1. Maximum throughput is one request per 4–5 cycles.
- Read data is sampled at the clock edge ending each read-state cycle.
- irqOut lags timerIrq by one cycle outside masked states.

## Test plan
- WR_TIME 0x0000_0001_FFFF_FFF0 accepted at cycle 0, RD_TIME accepted at cycle 5 -> respValid cycle 9, respData 0x0000_0001_FFFF_FFF3, respError 0.
- WR_TIME 0x0000_0001_FFFF_FFFD, then RD_TIME accepted 5 cycles later -> one retry; respValid at accept+6; respData 0x0000_0002_0000_0002.
- Timer stub whose high word changes on every read, with MAX_RETRY 2 -> respValid at accept+8, respError 1, exactly 2 retries.
- WR_CMP 0x0000_0000_0000_0100 with `mtime` 0x50 -> strobes are addr 8/FFFF_FFFF, 12/0, 8/0000_0100 on consecutive cycles; irqOut stays 0 throughout. irqOut rises exactly one cycle after timerIrq, when `mtime` reaches 0x100. RD_CMP then returns 0x100 at accept+3.
- Assert rst during W2 of WR_CMP -> all outputs zero immediately; reqReady 1 in the first cycle after release; a new RD_CMP completes normally.
- reqValid held high continuously -> no acceptance while busy; reqReady never 1 in a cycle with respValid; timerReadEnable and timerWriteEnable never both 1.
